// File: rtl/tlk2711_seq_ctrl.sv
// Command sequencer for a TLK2711 link: start pulse, timed run, stop/ack handshake, inter-run gap.
// Optional sweep steps the mode upward after each run; illegal modes and ack timeouts raise o_err.
module tlk2711_seq_ctrl #(
  parameter int GAP_CYCLES  = 64,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic        tx_clk,
  input  logic        rst,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [1:0]  i_cmd_mode,
  input  logic [15:0] i_cmd_len,
  input  logic        i_cmd_sweep,
  input  logic        i_abort,
  output logic        o_start,
  output logic [1:0]  o_mode,
  output logic        o_stop,
  input  logic        i_stop_ack,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [1:0]  o_err_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_STOP_WAIT,
    S_GAP
  } state_t;

  localparam logic [15:0] GAP_LAST    = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] ACK_LAST    = 16'(ACK_TIMEOUT - 1);
  localparam logic [1:0]  MODE_ILLEGAL = 2'd3;
  localparam logic [1:0]  MODE_LAST    = 2'd2;
  localparam logic [1:0]  ERR_ILLEGAL  = 2'd1;
  localparam logic [1:0]  ERR_TIMEOUT  = 2'd2;

  state_t      r_state;
  logic [15:0] r_len;
  logic        r_sweep;
  logic [15:0] r_run_cnt;
  logic [15:0] r_ack_cnt;
  logic [15:0] r_gap_cnt;
  logic        r_cmd_ready;
  logic        r_start;
  logic [1:0]  r_mode;
  logic        r_stop;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic [1:0]  r_err_code;

  logic        w_accept;
  logic        w_run_last;
  logic        w_ack_last;
  logic        w_gap_last;
  logic        w_sweep_next;

  assign w_accept     = i_cmd_valid && r_cmd_ready;
  assign w_run_last   = (r_run_cnt == (r_len - 16'd1));
  assign w_ack_last   = (r_ack_cnt == ACK_LAST);
  assign w_gap_last   = (r_gap_cnt == GAP_LAST);
  assign w_sweep_next = r_sweep && (r_mode < MODE_LAST);

  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_len       <= 16'd0;
      r_sweep     <= 1'b0;
      r_run_cnt   <= 16'd0;
      r_ack_cnt   <= 16'd0;
      r_gap_cnt   <= 16'd0;
      r_cmd_ready <= 1'b0;
      r_start     <= 1'b0;
      r_mode      <= 2'd0;
      r_stop      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= 2'd0;
    end else begin
      r_start <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_accept) begin
            r_len   <= (i_cmd_len == 16'd0) ? 16'd1 : i_cmd_len;
            r_sweep <= i_cmd_sweep;
            // Illegal mode is reported without ever leaving IDLE.
            if (i_cmd_mode == MODE_ILLEGAL) begin
              r_err      <= 1'b1;
              r_err_code <= ERR_ILLEGAL;
            end else begin
              r_mode      <= i_cmd_mode;
              r_start     <= 1'b1;
              r_cmd_ready <= 1'b0;
              r_busy      <= 1'b1;
              r_state     <= S_START;
            end
          end
        end

        S_START: begin
          r_run_cnt <= 16'd0;
          if (i_abort) begin
            r_sweep   <= 1'b0;
            r_stop    <= 1'b1;
            r_ack_cnt <= 16'd0;
            r_state   <= S_STOP_WAIT;
          end else begin
            r_state <= S_RUN;
          end
        end

        S_RUN: begin
          if (i_abort || w_run_last) begin
            if (i_abort) begin
              r_sweep <= 1'b0;
            end
            r_stop    <= 1'b1;
            r_ack_cnt <= 16'd0;
            r_state   <= S_STOP_WAIT;
          end else begin
            r_run_cnt <= r_run_cnt + 16'd1;
          end
        end

        S_STOP_WAIT: begin
          // An ack arriving on the final allowed cycle still counts as a clean stop.
          if (i_stop_ack) begin
            r_stop    <= 1'b0;
            r_gap_cnt <= 16'd0;
            r_state   <= S_GAP;
          end else if (w_ack_last) begin
            r_stop     <= 1'b0;
            r_err      <= 1'b1;
            r_err_code <= ERR_TIMEOUT;
            r_sweep    <= 1'b0;
            r_gap_cnt  <= 16'd0;
            r_state    <= S_GAP;
          end else begin
            r_ack_cnt <= r_ack_cnt + 16'd1;
          end
        end

        S_GAP: begin
          if (w_gap_last) begin
            if (w_sweep_next) begin
              r_mode  <= r_mode + 2'd1;
              r_start <= 1'b1;
              r_state <= S_START;
            end else begin
              r_done      <= 1'b1;
              r_busy      <= 1'b0;
              r_cmd_ready <= 1'b1;
              r_state     <= S_IDLE;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + 16'd1;
          end
        end

        default: begin
          r_stop      <= 1'b0;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign o_cmd_ready = r_cmd_ready;
  assign o_start     = r_start;
  assign o_mode      = r_mode;
  assign o_stop      = r_stop;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_err_code  = r_err_code;

  a_pulse_exclusive: assert property (@(posedge tx_clk) disable iff (rst)
    !((r_start && r_done) || (r_start && r_err) || (r_done && r_err)));

  a_ready_not_busy: assert property (@(posedge tx_clk) disable iff (rst)
    !(r_cmd_ready && r_busy));

endmodule

// File: tb/tb_tlk2711_seq_ctrl.sv
// Directed bench for tlk2711_seq_ctrl with a short gap and a 16-cycle ack timeout.
// A negedge monitor timestamps pulses; a responder acks o_stop after a programmable delay.
module tb_tlk2711_seq_ctrl;
  localparam int GAP = 8;
  localparam int ACK = 16;

  logic        tx_clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic [1:0]  i_cmd_mode = 2'd0;
  logic [15:0] i_cmd_len = 16'd0;
  logic        i_cmd_sweep = 1'b0;
  logic        i_abort = 1'b0;
  logic        o_start;
  logic [1:0]  o_mode;
  logic        o_stop;
  logic        i_stop_ack;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic [1:0]  o_err_code;

  tlk2711_seq_ctrl #(.GAP_CYCLES(GAP), .ACK_TIMEOUT(ACK)) dut (
    .tx_clk(tx_clk), .rst(rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_mode(i_cmd_mode), .i_cmd_len(i_cmd_len), .i_cmd_sweep(i_cmd_sweep),
    .i_abort(i_abort), .o_start(o_start), .o_mode(o_mode), .o_stop(o_stop),
    .i_stop_ack(i_stop_ack), .o_busy(o_busy), .o_done(o_done),
    .o_err(o_err), .o_err_code(o_err_code)
  );

  always #5 tx_clk = ~tx_clk;

  int cyc = 0;
  always @(posedge tx_clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  int n_start = 0, n_done = 0, n_err = 0, n_overlap = 0;
  int t_start = 0, t_done = 0, t_err = 0, t_stop_rise = 0, t_stop_fall = 0;
  int stop_run = 0, stop_len_last = 0;
  logic [1:0] err_code_seen = 2'd0;
  logic prev_stop = 1'b0;
  logic [1:0] start_mode_log [0:63];

  always @(negedge tx_clk) begin
    if (int'(o_start) + int'(o_done) + int'(o_err) > 1) n_overlap++;
    if (o_start) begin
      start_mode_log[n_start % 64] = o_mode;
      n_start++;
      t_start = cyc;
    end
    if (o_done) begin
      n_done++;
      t_done = cyc;
    end
    if (o_err) begin
      n_err++;
      t_err = cyc;
      err_code_seen = o_err_code;
    end
    if (o_stop) begin
      if (!prev_stop) begin
        t_stop_rise = cyc;
        stop_run = 1;
      end else begin
        stop_run++;
      end
    end else if (prev_stop) begin
      t_stop_fall = cyc;
      stop_len_last = stop_run;
    end
    prev_stop = o_stop;
  end

  // ack_delay < 0 means the far end never acknowledges.
  int ack_delay = 0;
  int stop_age = 0;
  always @(negedge tx_clk) begin
    if (o_stop) begin
      i_stop_ack = (ack_delay >= 0) && (stop_age == ack_delay);
      stop_age++;
    end else begin
      i_stop_ack = 1'b0;
      stop_age = 0;
    end
  end

  task automatic tick();
    @(negedge tx_clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] m, input logic [15:0] l, input logic s, output int t_acc);
    i_cmd_valid = 1'b1;
    i_cmd_mode  = m;
    i_cmd_len   = l;
    i_cmd_sweep = s;
    tick();
    t_acc = cyc;
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (n_done >= target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (n_done >= target) ok = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_cmp++; if ({o_cmd_ready, o_start, o_mode, o_stop, o_busy, o_done, o_err, o_err_code} !== 10'd0) begin
      n_bad++; $display("FAIL reset_outputs: got %b expected all zero",
        {o_cmd_ready, o_start, o_mode, o_stop, o_busy, o_done, o_err, o_err_code});
    end
    rst = 1'b0;
    #1;
    n_cmp++; if (o_cmd_ready !== 1'b0) begin n_bad++; $display("FAIL ready_before_edge: got %b expected 0", o_cmd_ready); end
    @(posedge tx_clk); #1;
    n_cmp++; if (o_cmd_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_edge: got %b expected 1", o_cmd_ready); end
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b expected 0", o_busy); end
    tick();
  endtask

  task automatic test_normal();
    int s0, d0, e0, ta;
    bit ok;
    s0 = n_start; d0 = n_done; e0 = n_err;
    ack_delay = 3;
    issue(2'd0, 16'd100, 1'b0, ta);
    wait_done(d0 + 1, 400, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL normal_done_timeout: got %0d dones expected %0d", n_done - d0, 1); end
    n_cmp++; if (n_start - s0 != 1) begin n_bad++; $display("FAIL normal_starts: got %0d expected 1", n_start - s0); end
    n_cmp++; if (t_start != ta) begin n_bad++; $display("FAIL normal_start_cycle: got %0d expected %0d", t_start, ta); end
    n_cmp++; if (start_mode_log[s0 % 64] !== 2'd0) begin n_bad++; $display("FAIL normal_mode: got %0d expected 0", start_mode_log[s0 % 64]); end
    n_cmp++; if (t_stop_rise - t_start != 101) begin n_bad++; $display("FAIL normal_run_len: got %0d expected 101", t_stop_rise - t_start); end
    n_cmp++; if (stop_len_last != 4) begin n_bad++; $display("FAIL normal_stop_len: got %0d expected 4", stop_len_last); end
    n_cmp++; if (t_done - t_stop_fall != GAP) begin n_bad++; $display("FAIL normal_gap: got %0d expected %0d", t_done - t_stop_fall, GAP); end
    n_cmp++; if (n_err != e0) begin n_bad++; $display("FAIL normal_no_err: got %0d expected 0", n_err - e0); end
    n_cmp++; if (o_cmd_ready !== 1'b1 || o_busy !== 1'b0) begin n_bad++; $display("FAIL normal_idle: got ready %b busy %b expected 1 0", o_cmd_ready, o_busy); end
  endtask

  task automatic test_len_zero();
    int s0, d0, ta;
    bit ok;
    s0 = n_start; d0 = n_done;
    ack_delay = 0;
    issue(2'd2, 16'd0, 1'b0, ta);
    wait_done(d0 + 1, 100, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL len0_done_timeout: got %0d dones expected 1", n_done - d0); end
    n_cmp++; if (t_stop_rise - t_start != 2) begin n_bad++; $display("FAIL len0_run_len: got %0d expected 2", t_stop_rise - t_start); end
    n_cmp++; if (stop_len_last != 1) begin n_bad++; $display("FAIL len0_stop_len: got %0d expected 1", stop_len_last); end
    n_cmp++; if (start_mode_log[s0 % 64] !== 2'd2) begin n_bad++; $display("FAIL len0_mode: got %0d expected 2", start_mode_log[s0 % 64]); end
  endtask

  task automatic test_sweep(input logic [1:0] first_mode, input int exp_starts);
    int s0, d0, ta;
    bit ok;
    logic [1:0] exp_mode;
    s0 = n_start; d0 = n_done;
    ack_delay = 0;
    issue(first_mode, 16'd10, 1'b1, ta);
    wait_done(d0 + 1, 300, ok);
    repeat (5) tick();
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL sweep_done_timeout: got %0d dones expected 1", n_done - d0); end
    n_cmp++; if (n_start - s0 != exp_starts) begin n_bad++; $display("FAIL sweep_starts: got %0d expected %0d", n_start - s0, exp_starts); end
    n_cmp++; if (n_done - d0 != 1) begin n_bad++; $display("FAIL sweep_single_done: got %0d expected 1", n_done - d0); end
    for (int k = 0; k < exp_starts; k++) begin
      exp_mode = first_mode + 2'(k);
      n_cmp++; if (start_mode_log[(s0 + k) % 64] !== exp_mode) begin
        n_bad++; $display("FAIL sweep_mode_%0d: got %0d expected %0d", k, start_mode_log[(s0 + k) % 64], exp_mode);
      end
    end
  endtask

  task automatic test_illegal();
    int s0, e0, ta;
    s0 = n_start; e0 = n_err;
    n_cmp++; if (o_cmd_ready !== 1'b1) begin n_bad++; $display("FAIL illegal_ready_pre: got %b expected 1", o_cmd_ready); end
    issue(2'd3, 16'd5, 1'b0, ta);
    n_cmp++; if (o_err !== 1'b1 || o_err_code !== 2'd1) begin n_bad++; $display("FAIL illegal_err: got err %b code %0d expected 1 1", o_err, o_err_code); end
    n_cmp++; if (o_cmd_ready !== 1'b1 || o_busy !== 1'b0) begin n_bad++; $display("FAIL illegal_idle: got ready %b busy %b expected 1 0", o_cmd_ready, o_busy); end
    repeat (4) tick();
    n_cmp++; if (n_err - e0 != 1 || t_err != ta) begin n_bad++; $display("FAIL illegal_err_pulse: got %0d pulses at %0d expected 1 at %0d", n_err - e0, t_err, ta); end
    n_cmp++; if (n_start != s0) begin n_bad++; $display("FAIL illegal_no_start: got %0d expected 0", n_start - s0); end
    n_cmp++; if (o_err_code !== 2'd1) begin n_bad++; $display("FAIL illegal_code_hold: got %0d expected 1", o_err_code); end
  endtask

  task automatic test_timeout();
    int s0, d0, e0, ta;
    bit ok;
    s0 = n_start; d0 = n_done; e0 = n_err;
    ack_delay = -1;
    issue(2'd0, 16'd4, 1'b1, ta);
    wait_done(d0 + 1, 200, ok);
    repeat (3) tick();
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL timeout_done_timeout: got %0d dones expected 1", n_done - d0); end
    n_cmp++; if (stop_len_last != ACK) begin n_bad++; $display("FAIL timeout_stop_len: got %0d expected %0d", stop_len_last, ACK); end
    n_cmp++; if (n_err - e0 != 1 || err_code_seen !== 2'd2) begin n_bad++; $display("FAIL timeout_err: got %0d pulses code %0d expected 1 code 2", n_err - e0, err_code_seen); end
    n_cmp++; if (t_err != t_stop_fall) begin n_bad++; $display("FAIL timeout_err_cycle: got %0d expected %0d", t_err, t_stop_fall); end
    n_cmp++; if (t_done - t_stop_fall != GAP) begin n_bad++; $display("FAIL timeout_gap: got %0d expected %0d", t_done - t_stop_fall, GAP); end
    n_cmp++; if (n_start - s0 != 1) begin n_bad++; $display("FAIL timeout_sweep_cancel: got %0d starts expected 1", n_start - s0); end
    n_cmp++; if (o_err_code !== 2'd2) begin n_bad++; $display("FAIL timeout_code_hold: got %0d expected 2", o_err_code); end
  endtask

  task automatic test_abort_run();
    int s0, d0, e0, ta, t_ab;
    bit ok;
    s0 = n_start; d0 = n_done; e0 = n_err;
    ack_delay = 2;
    issue(2'd0, 16'd1000, 1'b1, ta);
    repeat (5) tick();
    i_abort = 1'b1;
    t_ab = cyc;
    tick();
    i_abort = 1'b0;
    n_cmp++; if (o_stop !== 1'b1 || t_stop_rise != t_ab + 1) begin n_bad++; $display("FAIL abort_stop: got stop %b at %0d expected 1 at %0d", o_stop, t_stop_rise, t_ab + 1); end
    for (int i = 0; i < 10 && o_stop; i++) tick();
    // Abort held during the gap must not disturb its length.
    i_abort = 1'b1;
    repeat (3) tick();
    i_abort = 1'b0;
    wait_done(d0 + 1, 100, ok);
    repeat (3) tick();
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL abort_done_timeout: got %0d dones expected 1", n_done - d0); end
    n_cmp++; if (stop_len_last != 3) begin n_bad++; $display("FAIL abort_stop_len: got %0d expected 3", stop_len_last); end
    n_cmp++; if (t_done - t_stop_fall != GAP) begin n_bad++; $display("FAIL abort_gap: got %0d expected %0d", t_done - t_stop_fall, GAP); end
    n_cmp++; if (n_start - s0 != 1 || n_err != e0) begin n_bad++; $display("FAIL abort_counts: got %0d starts %0d errs expected 1 0", n_start - s0, n_err - e0); end
  endtask

  task automatic test_abort_start();
    int s0, d0, ta;
    bit ok;
    s0 = n_start; d0 = n_done;
    ack_delay = 0;
    issue(2'd1, 16'd50, 1'b1, ta);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    n_cmp++; if (o_stop !== 1'b1 || t_stop_rise != ta + 1) begin n_bad++; $display("FAIL abort_start_stop: got stop %b at %0d expected 1 at %0d", o_stop, t_stop_rise, ta + 1); end
    wait_done(d0 + 1, 60, ok);
    repeat (3) tick();
    n_cmp++; if (!ok || n_start - s0 != 1) begin n_bad++; $display("FAIL abort_start_counts: got %0d dones %0d starts expected 1 1", n_done - d0, n_start - s0); end
  endtask

  task automatic test_reset_mid();
    int s0, d0, e0, ta;
    bit ok;
    d0 = n_done; e0 = n_err;
    ack_delay = -1;
    issue(2'd0, 16'd2, 1'b0, ta);
    for (int i = 0; i < 20 && !o_stop; i++) tick();
    n_cmp++; if (o_stop !== 1'b1) begin n_bad++; $display("FAIL rstmid_stop_pre: got %b expected 1", o_stop); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (o_stop !== 1'b0 || o_busy !== 1'b0 || o_cmd_ready !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_async: got stop %b busy %b ready %b expected 0 0 0", o_stop, o_busy, o_cmd_ready);
    end
    repeat (3) tick();
    rst = 1'b0;
    repeat (ACK + GAP + 5) tick();
    n_cmp++; if (n_done != d0 || n_err != e0) begin n_bad++; $display("FAIL rstmid_silent: got %0d dones %0d errs expected 0 0", n_done - d0, n_err - e0); end
    s0 = n_start; d0 = n_done;
    ack_delay = 0;
    n_cmp++; if (o_cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready: got %b expected 1", o_cmd_ready); end
    issue(2'd0, 16'd3, 1'b0, ta);
    wait_done(d0 + 1, 60, ok);
    n_cmp++; if (!ok || n_start - s0 != 1) begin n_bad++; $display("FAIL rstmid_recover: got %0d dones %0d starts expected 1 1", n_done - d0, n_start - s0); end
    n_cmp++; if (t_stop_rise - t_start != 4) begin n_bad++; $display("FAIL rstmid_run_len: got %0d expected 4", t_stop_rise - t_start); end
  endtask

  task automatic test_pulse_exclusive();
    n_cmp++; if (n_overlap != 0) begin n_bad++; $display("FAIL pulse_overlap: got %0d cycles expected 0", n_overlap); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_len_zero();
    test_sweep(2'd0, 3);
    test_sweep(2'd1, 2);
    test_illegal();
    test_timeout();
    test_abort_run();
    test_abort_start();
    test_reset_mid();
    test_pulse_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tlk2711_seq_ctrl.md
TLK2711_SEQ_CTRL -- requirements
Module: tlk2711_seq_ctrl

Interface
REQ-001 Parameter GAP_CYCLES, default 64: idle cycles between stop-ack and the next start or done (range 1..65535).
REQ-002 Parameter ACK_TIMEOUT, default 1024: cycles o_stop may wait for i_stop_ack before timeout (range 1..65535).
REQ-003 Port tx_clk  in  1: sole clock; all logic on rising edge.
REQ-004 Port rst  in  1: asynchronous, active-high reset.
REQ-005 Port i_cmd_valid  in  1: command request.
REQ-006 Port o_cmd_ready  out  1: high only in IDLE.
REQ-007 Port i_cmd_mode  in  2: 0 normal, 1 loopback, 2 K-code, 3 illegal.
REQ-008 Port i_cmd_len  in  16: run length in cycles; 0 treated as 1.
REQ-009 Port i_cmd_sweep  in  1: step mode upward after each run, up to 2.
REQ-010 Port i_abort  in  1: terminate the current run early.
REQ-011 Port o_start  out  1: one-cycle start pulse to tlk2711 i_start.
REQ-012 Port o_mode  out  2: mode to tlk2711 i_mode; stable from o_start through stop-ack.
REQ-013 Port o_stop  out  1: level to tlk2711 i_stop.
REQ-014 Port i_stop_ack  in  1: from tlk2711 o_stop_ack.
REQ-015 Port o_busy  out  1: high in every state except IDLE.
REQ-016 Port o_done  out  1: one-cycle pulse when a command (including its sweep) completes.
REQ-017 Port o_err  out  1: one-cycle error pulse; o_err_code  out  2 holds the last code (1 illegal mode, 2 ack timeout) until the next o_err.

Function
REQ-018 States are IDLE, START, RUN, STOP_WAIT and GAP; encoding is free.
REQ-019 Accept a command on the edge where i_cmd_valid and o_cmd_ready are both high; latch mode, len (0 becomes 1) and sweep.
REQ-020 Accepted mode 3: no start is issued; o_err pulses on the next cycle with code 1; state stays IDLE.
REQ-021 Accepted legal mode: START on the next cycle; o_start=1 for exactly that cycle; o_mode=latched mode.
REQ-022 RUN lasts exactly len cycles, counted by a 16-bit counter cleared on entry; then STOP_WAIT.
REQ-023 In STOP_WAIT, o_stop=1 from the first cycle; i_stop_ack is sampled every STOP_WAIT cycle, including the first.
REQ-024 Ack sampled high: o_stop=0 on the next cycle; enter GAP.
REQ-025 Ack not seen within ACK_TIMEOUT STOP_WAIT cycles: o_stop=0, o_err pulses with code 2, enter GAP, sweep cancelled.
REQ-026 i_abort high in START or RUN: next state is STOP_WAIT (skips the rest of RUN; the start pulse already issued stands); sweep cancelled.
REQ-027 i_abort is ignored in IDLE, STOP_WAIT and GAP.
REQ-028 GAP lasts exactly GAP_CYCLES cycles.
REQ-029 GAP exit with sweep active and mode<2: mode increments, same len, enter START.
REQ-030 Any other GAP exit: o_done pulses for one cycle and the state returns to IDLE.
REQ-031 o_start, o_done and o_err never assert in the same cycle as each other.

Reset
REQ-032 While rst=1, state is IDLE and all counters are 0; o_start=0, o_mode=0, o_stop=0, o_busy=0, o_done=0, o_err=0, o_err_code=0, o_cmd_ready=0.
REQ-033 o_cmd_ready goes high on the first clock edge after rst deasserts.
REQ-034 Reset mid-operation drops o_stop immediately and discards the command, with no o_done and no o_err.

Verification
REQ-035 Mode 0, len 100, sweep 0, ack 3 cycles after o_stop -> one o_start, o_stop for 4 cycles, o_done exactly GAP_CYCLES cycles after o_stop falls.
REQ-036 Mode 0, len 10, sweep 1 -> three o_start pulses with o_mode 0, 1, 2, then a single o_done.
REQ-037 Mode 3 -> no o_start; o_err one cycle after accept with code 1; o_cmd_ready stays high.
REQ-038 i_stop_ack tied low, ACK_TIMEOUT=16 -> o_stop high exactly 16 cycles, o_err code 2, then o_done after the gap.
REQ-039 i_abort 5 cycles into a len=1000 run with sweep 1 -> o_stop the next cycle, no further o_start, o_done after the gap.
REQ-040 rst asserted during STOP_WAIT -> o_stop=0 asynchronously; no o_done; a new command is accepted normally after release.
